// File: rtl/decode_bundle_pipe.sv
// -----------------------------------------------------------------------------
// decode_bundle_pipe
//
// Pipeline stage between decode and execute for the packed decoded-control
// word. It is a two-entry skid buffer (head + skid) with valid/ready on both
// sides and a synchronous flush for branch/jump redirects. While out_valid is
// low, the side-effect fields selected by KILL_MASK are forced to zero, so an
// idle or flushed slot always reads as a NOP. A saturating bubble counter
// counts cycles where execute was ready but nothing was offered.
//
// Ports:
//   clk         in   1       clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   in_word     in   DATA_W  control word from decode
//   in_valid    in   1       in_word valid this cycle
//   in_ready    out  1       stage can accept this cycle (registered)
//   out_word    out  DATA_W  head word to execute, masked when not valid
//   out_valid   out  1       head entry holds a valid word
//   out_ready   in   1       execute consumes the head this cycle
//   flush       in   1       synchronous kill of held and incoming words
//   occupancy   out  2       number of valid entries, 0..2
//   bubble_cnt  out  CNT_W   saturating count of bubble cycles
//   cnt_clr     in   1       synchronous clear of bubble_cnt
// -----------------------------------------------------------------------------
module decode_bundle_pipe #(
    parameter int unsigned       DATA_W    = 40,
    parameter logic [DATA_W-1:0] KILL_MASK = 40'h00_027F_8000,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt,
    input  logic              cnt_clr
);

    logic              head_v;
    logic              skid_v;
    logic [DATA_W-1:0] head_d;
    logic [DATA_W-1:0] skid_d;
    logic              acc;
    logic              deq;

    // in_ready depends only on registered state, so there is no combinational
    // path from out_ready back to the decoder.
    assign in_ready  = !skid_v;
    assign acc       = in_valid & in_ready;
    assign deq       = head_v & out_ready;

    assign out_valid = head_v;
    assign out_word  = head_v ? head_d : (head_d & ~KILL_MASK);
    assign occupancy = {1'b0, head_v} + {1'b0, skid_v};

    // Entry state. The skid entry only ever fills while the head is valid, so
    // the skid never holds data ahead of the head and order is preserved.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_v <= 1'b0;
            skid_v <= 1'b0;
            // NOTE: the data registers are reset too (not just the valids)
            // because the masked out_word is visible while idle and must read
            // as zero straight out of reset.
            head_d <= '0;
            skid_d <= '0;
        end else if (flush) begin
            // Data registers hold; masking on out_word hides their contents.
            head_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (skid_v) begin
            // FULL: in_ready is low, so only a dequeue can happen.
            if (deq) begin
                head_d <= skid_d;
                skid_v <= 1'b0;
            end
        end else if (head_v) begin
            // ONE
            if (acc && deq) begin
                head_d <= in_word;
            end else if (acc) begin
                skid_d <= in_word;
                skid_v <= 1'b1;
            end else if (deq) begin
                head_v <= 1'b0;
            end
        end else if (acc) begin
            // EMPTY
            head_d <= in_word;
            head_v <= 1'b1;
        end
    end

    // Bubble counter: execute ready, nothing to give it. Clear wins over
    // increment; flush has no effect here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            bubble_cnt <= '0;
        end else if (out_ready && !head_v && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_bundle_pipe.sv
// -----------------------------------------------------------------------------
// tb_decode_bundle_pipe
//
// Directed self-checking bench for decode_bundle_pipe (CNT_W=4 so the bubble
// counter saturates quickly). Inputs are driven 1 time unit after the rising
// edge; outputs are checked at the same point, i.e. they show the state
// written by the preceding edge.
// -----------------------------------------------------------------------------
module tb_decode_bundle_pipe;

    localparam int unsigned       DATA_W = 40;
    localparam int unsigned       CNT_W  = 4;
    localparam logic [DATA_W-1:0] MASK   = 40'h00_027F_8000;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] in_word;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_word;
    logic              out_valid;
    logic              out_ready;
    logic              flush;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  bubble_cnt;
    logic              cnt_clr;

    int checks;
    int failures;

    decode_bundle_pipe #(
        .DATA_W   (DATA_W),
        .KILL_MASK(MASK),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .occupancy (occupancy),
        .bubble_cnt(bubble_cnt),
        .cnt_clr   (cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Convenience: check the four handshake-visible outputs at once.
    task automatic check_state(input string tag, input logic ov, input logic [DATA_W-1:0] ow,
                               input logic ir, input logic [1:0] occ);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
        check({tag, ".out_word"},  64'(out_word),  64'(ow));
        check({tag, ".in_ready"},  64'(in_ready),  64'(ir));
        check({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
    endtask

    logic [DATA_W-1:0] words [9];

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_word   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check_state("reset", 1'b0, 40'h0, 1'b1, 2'd0);
        check("reset.bubble_cnt", 64'(bubble_cnt), 64'd0);
        rst_n = 1'b1;
        step();

        // ---------------- passthrough ----------------
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_word   = 40'h12_3456_789A;
        step();
        check_state("pass0", 1'b1, 40'h12_3456_789A, 1'b1, 2'd1);
        in_word = 40'hFF_FFFF_FFFF;
        step();
        check_state("pass1", 1'b1, 40'hFF_FFFF_FFFF, 1'b1, 2'd1);
        in_valid = 1'b0;
        step();
        // Idle head of all ones reads back with the side-effect fields killed.
        check_state("pass_idle", 1'b0, 40'hFF_FD80_7FFF, 1'b1, 2'd0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_word   = 40'h11_1111_1111;  // A
        step();
        check_state("bp_a", 1'b1, 40'h11_1111_1111, 1'b1, 2'd1);
        in_word = 40'h22_2222_2222;    // B
        step();
        check_state("bp_b", 1'b1, 40'h11_1111_1111, 1'b0, 2'd2);
        in_word = 40'h33_3333_3333;    // C, must be held by the source
        step();
        check_state("bp_c_held", 1'b1, 40'h11_1111_1111, 1'b0, 2'd2);
        out_ready = 1'b1;              // A leaves; C still not accepted
        step();
        check_state("bp_rel_b", 1'b1, 40'h22_2222_2222, 1'b1, 2'd1);
        step();                        // B leaves, C accepted
        check_state("bp_rel_c", 1'b1, 40'h33_3333_3333, 1'b1, 2'd1);
        in_valid = 1'b0;
        step();                        // C leaves
        check_state("bp_drain", 1'b0, 40'h33_3333_3333 & ~MASK, 1'b1, 2'd0);

        // ---------------- flush while FULL ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_word   = 40'hFF_FFFF_FFFF;
        step();
        in_word = 40'h44_4444_4444;
        step();
        check_state("fl_full", 1'b1, 40'hFF_FFFF_FFFF, 1'b0, 2'd2);
        flush   = 1'b1;
        in_word = 40'h55_5555_5555;    // offered during flush, must vanish
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_state("fl_after", 1'b0, 40'hFF_FD80_7FFF, 1'b1, 2'd0);
        out_ready = 1'b1;
        step();
        check_state("fl_quiet", 1'b0, 40'hFF_FD80_7FFF, 1'b1, 2'd0);

        // Flush from EMPTY drops a word that would otherwise be accepted.
        in_valid = 1'b1;
        in_word  = 40'h66_6666_6666;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_state("fl_empty", 1'b0, 40'hFF_FD80_7FFF, 1'b1, 2'd0);

        // ---------------- bubble counter ----------------
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("bub_clr0", 64'(bubble_cnt), 64'd0);
        repeat (5) step();
        check("bub_5", 64'(bubble_cnt), 64'd5);
        out_ready = 1'b0;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        check("bub_flush_hold", 64'(bubble_cnt), 64'd5);
        out_ready = 1'b1;
        repeat (20) step();
        check("bub_sat", 64'(bubble_cnt), 64'd15);
        cnt_clr = 1'b1;                // clear together with a bubble
        step();
        cnt_clr   = 1'b0;
        out_ready = 1'b0;
        check("bub_clr_prio", 64'(bubble_cnt), 64'd0);

        // ---------------- sustained acc & deq in ONE ----------------
        for (int i = 0; i < 9; i++) words[i] = 40'hA0_0000_0000 + 40'(i * 40'h01_0101_0101);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_word = words[i];
            step();
            check_state($sformatf("stream%0d", i), 1'b1, words[i], 1'b1, 2'd1);
        end
        in_valid = 1'b0;
        step();
        check_state("stream_end", 1'b0, words[8] & ~MASK, 1'b1, 2'd0);

        // ---------------- asynchronous reset mid-stream ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_word   = 40'hAB_0200_0001;
        step();
        in_word = 40'h77_7777_7777;
        step();
        in_valid = 1'b0;
        check_state("rst_full", 1'b1, 40'hAB_0200_0001, 1'b0, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("rst_async", 1'b0, 40'h0, 1'b1, 2'd0);
        check("rst_async.bubble_cnt", 64'(bubble_cnt), 64'd0);
        rst_n = 1'b1;
        step();
        check_state("rst_after", 1'b0, 40'h0, 1'b1, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
